// File: rtl/int2flt_seq.sv
// Sequential 16-bit two's-complement integer to IEEE-754 half-precision converter.
// Reads the integer from data memory, normalizes one bit per cycle, rounds to nearest-even, writes back.
module int2flt_seq #(
    parameter int ADDR_W   = 8,
    parameter int SRC_ADDR = 0,
    parameter int DST_ADDR = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              done,
    output logic [ADDR_W-1:0] dm_addr,
    output logic              dm_wr_en,
    output logic [7:0]        dm_wdata,
    input  logic [7:0]        dm_rdata
);

    localparam int SRC_HI_I = SRC_ADDR + 1;
    localparam int DST_HI_I = DST_ADDR + 1;
    localparam logic [ADDR_W-1:0] SRC_LO = SRC_ADDR[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] SRC_HI = SRC_HI_I[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] DST_LO = DST_ADDR[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] DST_HI = DST_HI_I[ADDR_W-1:0];

    typedef enum logic [2:0] {
        IDLE, RD_LO, RD_HI, NORM, ROUND, WR_LO, WR_HI, DONE
    } state_t;

    state_t      state;
    logic        start_q;
    logic [7:0]  lo_byte;
    logic        sign;
    logic [15:0] mag;
    logic [4:0]  exp_r;
    logic [15:0] result;

    logic [15:0] x_in;
    logic [15:0] mag_in;
    logic        rnd_up;
    logic [10:0] mant_rnd;
    logic [4:0]  exp_rnd;
    logic [15:0] rnd_res;

    // The full-width negate maps 0x8000 onto itself, which is exactly the magnitude wanted.
    always_comb begin
        x_in   = {dm_rdata, lo_byte};
        mag_in = x_in[15] ? (~x_in + 16'd1) : x_in;
    end

    // Guard is mag[4], sticky is mag[3:0]; ties go to the even mantissa.
    always_comb begin
        rnd_up   = mag[4] & ((|mag[3:0]) | mag[5]);
        mant_rnd = {1'b0, mag[14:5]} + {10'd0, rnd_up};
        exp_rnd  = mant_rnd[10] ? exp_r + 5'd1 : exp_r;
        rnd_res  = {sign, exp_rnd, mant_rnd[9:0]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            start_q  <= 1'b0;
            done     <= 1'b0;
            dm_addr  <= '0;
            dm_wr_en <= 1'b0;
            dm_wdata <= 8'd0;
            lo_byte  <= 8'd0;
            sign     <= 1'b0;
            mag      <= 16'd0;
            exp_r    <= 5'd0;
            result   <= 16'd0;
        end else begin
            start_q <= start;
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start_q && !start) begin
                        dm_addr <= SRC_LO;
                        state   <= RD_LO;
                    end
                end
                RD_LO: begin
                    lo_byte <= dm_rdata;
                    dm_addr <= SRC_HI;
                    state   <= RD_HI;
                end
                RD_HI: begin
                    sign  <= x_in[15];
                    mag   <= mag_in;
                    exp_r <= 5'd30;
                    if (mag_in == 16'd0) begin
                        // Zero bypasses normalization and always yields +0.
                        result   <= 16'd0;
                        dm_addr  <= DST_LO;
                        dm_wr_en <= 1'b1;
                        dm_wdata <= 8'd0;
                        state    <= WR_LO;
                    end else begin
                        state <= NORM;
                    end
                end
                NORM: begin
                    if (!mag[15]) begin
                        mag   <= {mag[14:0], 1'b0};
                        exp_r <= exp_r - 5'd1;
                    end else begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    result   <= rnd_res;
                    dm_addr  <= DST_LO;
                    dm_wr_en <= 1'b1;
                    dm_wdata <= rnd_res[7:0];
                    state    <= WR_LO;
                end
                WR_LO: begin
                    dm_addr  <= DST_HI;
                    dm_wdata <= result[15:8];
                    state    <= WR_HI;
                end
                WR_HI: begin
                    dm_wr_en <= 1'b0;
                    done     <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_int2flt_seq.sv
// Randomized bench for int2flt_seq: arithmetic reference model of the half-float result and
// its cycle timing, checked on every cycle of each conversion, plus literal anchor cases.
module tb_int2flt_seq;

    logic       clk;
    logic       reset;
    logic       start;
    logic       done;
    logic [7:0] dm_addr;
    logic       dm_wr_en;
    logic [7:0] dm_wdata;
    logic [7:0] dm_rdata;

    logic [7:0] mem [256];
    int tests;
    int fails;

    assign dm_rdata = mem[dm_addr];

    int2flt_seq #(.ADDR_W(8), .SRC_ADDR(0), .DST_ADDR(2)) dut (
        .clk(clk), .reset(reset), .start(start), .done(done),
        .dm_addr(dm_addr), .dm_wr_en(dm_wr_en), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic int msb_pos(input int m);
        int p;
        p = 0;
        while ((m >> (p + 1)) != 0) p++;
        return p;
    endfunction

    function automatic int abs_val(input logic [15:0] x);
        int v;
        v = $signed(x);
        return (v < 0) ? -v : v;
    endfunction

    // Real-number rounding of |x| to 11 significant bits, ties to even.
    function automatic logic [15:0] ref_half(input logic [15:0] x);
        int m, p, e, q, sh, rem, half;
        logic s;
        s = x[15];
        m = abs_val(x);
        if (m == 0) return 16'h0000;
        p = msb_pos(m);
        e = p + 15;
        if (p <= 10) begin
            q = m << (10 - p);
        end else begin
            sh   = p - 10;
            q    = m >> sh;
            rem  = m - (q << sh);
            half = 1 << (sh - 1);
            if (rem > half || (rem == half && (q % 2) == 1)) q++;
            if (q == 2048) begin
                q = 1024;
                e++;
            end
        end
        return {s, 5'(e), 10'(q & 1023)};
    endfunction

    function automatic int ref_lat(input logic [15:0] x);
        int m;
        m = abs_val(x);
        if (m == 0) return 5;
        return 7 + (15 - msb_pos(m));
    endfunction

    function automatic logic [31:0] obs();
        return {14'd0, done, dm_wr_en, dm_wr_en ? dm_addr : 8'h00, dm_wr_en ? dm_wdata : 8'h00};
    endfunction

    // Pulse start, launch on its falling edge, then compare outputs every cycle of the run.
    task automatic run_conv(input logic [15:0] x, input logic [15:0] res, input int lat,
                            input bit toggle);
        logic [31:0] exp_o;
        mem[0] = x[7:0];
        mem[1] = x[15:8];
        mem[2] = 8'($urandom);
        mem[3] = 8'($urandom);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= lat + 2; k++) begin
            @(negedge clk);
            if (k == lat - 2)      exp_o = {14'd0, 2'b01, 8'd2, res[7:0]};
            else if (k == lat - 1) exp_o = {14'd0, 2'b01, 8'd3, res[15:8]};
            else if (k == lat)     exp_o = {14'd0, 2'b10, 16'd0};
            else                   exp_o = 32'd0;
            chk($sformatf("x%h_c%0d", x, k), obs(), exp_o);
            if (dm_wr_en) mem[dm_addr] = dm_wdata;
            start = (toggle && k < lat - 3) ? 1'($urandom) : 1'b0;
        end
        chk($sformatf("mem_x%h", x), {16'd0, mem[3], mem[2]}, {16'd0, res});
    endtask

    initial begin
        logic [15:0] x;
        logic [15:0] saved;
        tests = 0;
        fails = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        reset = 1'b0;
        start = 1'b0;
        #12;
        chk("reset_state", obs() | {8'd0, dm_addr, 8'd0, dm_wdata},
            32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Pin the model itself against hand-derived encodings.
        chk("model_0001", {16'd0, ref_half(16'h0001)}, 32'h3C00);
        chk("model_7fff", {16'd0, ref_half(16'h7FFF)}, 32'h7800);
        chk("model_0803", {16'd0, ref_half(16'h0803)}, 32'h6802);
        chk("model_lat_8000", ref_lat(16'h8000), 32'd7);

        run_conv(16'h0001, 16'h3C00, 22, 1'b0);
        run_conv(16'hFFFF, 16'hBC00, 22, 1'b0);
        run_conv(16'h8000, 16'hF800, 7, 1'b0);
        run_conv(16'h0000, 16'h0000, 5, 1'b0);
        run_conv(16'h7FFF, 16'h7800, 8, 1'b0);
        run_conv(16'h0801, 16'h6800, 11, 1'b0);
        run_conv(16'h0803, 16'h6802, 11, 1'b1);

        // Reset in the middle of normalizing 0x0001 must abort without writes.
        mem[0] = 8'h01;
        mem[1] = 8'h00;
        mem[2] = 8'hA5;
        mem[3] = 8'h5A;
        saved  = 16'h5AA5;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= 10; k++) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_abort_outs", {14'd0, done, dm_wr_en, dm_addr, 8'd0}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst_c%0d", k), obs(), 32'd0);
            if (dm_wr_en) mem[dm_addr] = dm_wdata;
        end
        chk("rst_mem_kept", {16'd0, mem[3], mem[2]}, {16'd0, saved});
        run_conv(16'h0001, 16'h3C00, 22, 1'b0);

        for (int n = 0; n < 1500; n++) begin
            if (n % 2 == 0) x = 16'($urandom);
            else begin
                x = 16'($urandom_range(0, 32767) >> $urandom_range(0, 15));
                if ($urandom_range(0, 1) == 1) x = ~x + 16'd1;
            end
            run_conv(x, ref_half(x), ref_lat(x), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
